// File: rtl/pixel_writeback_pkg.sv
// Shared definitions for the pixel write-back path: FSM state encodings
// and default widths common with the read-side window address generator.
package pixel_writeback_pkg;

    // One-hot controller states
    typedef enum logic [2:0] {
        WB_IDLE     = 3'b001,
        WB_WRITE    = 3'b010,
        WB_COMPLETE = 3'b100
    } wb_state_e;

    // Widths shared with the read-side addressing logic
    localparam int WB_ADDR_W     = 17;
    localparam int WB_ROW_W      = 11;
    localparam int WB_COL_W      = 11;
    localparam int WB_DATA_W     = 8;
    localparam int WB_FIFO_DEPTH = 4;

endpackage

// File: rtl/pixel_writeback_fifo.sv
// Small skid FIFO for the write-back path, extra-bit pointer full/empty.
// Ports: clk, rst (async active-low), push/din, pop/dout, full, empty.
module writeback_fifo
    import pixel_writeback_pkg::*;
#(
    parameter int dataWidth = WB_DATA_W,
    parameter int fifoDepth = WB_FIFO_DEPTH  // power of 2, >= 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [dataWidth-1:0] din,
    input  logic                 pop,
    output logic [dataWidth-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int PW = $clog2(fifoDepth);

    logic [PW:0]          wr_ptr_q, wr_ptr_d;
    logic [PW:0]          rd_ptr_q, rd_ptr_d;
    logic [dataWidth-1:0] mem_q [fifoDepth];
    logic                 push_ok;
    logic                 pop_ok;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        // Same index, different wrap bit: writer is a full lap ahead
        full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + (PW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop_ok);
        dout     = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pixel_writeback.sv
// Buffers raster-order output pixels and writes them to frame memory at
// linear addresses row*colMax+col (built by accumulation, no multiply).
// Ports: clk, rst (async active-low), start/rowMax/colMax frame setup,
// inValid/inReady/inData upstream, wrEn/wrReady/wrAddress/wrData memory,
// busy (writing), done (frame complete, level).
// Macro WB_CLAMP_EN: inData becomes signed dataWidth+2 bits and is
// clamped to [0, 2^dataWidth-1] before entering the FIFO.
module pixel_writeback
    import pixel_writeback_pkg::*;
#(
    parameter int addressBitWidth = WB_ADDR_W,
    parameter int rowBitWidth     = WB_ROW_W,
    parameter int colBitWidth     = WB_COL_W,
    parameter int dataWidth       = WB_DATA_W,
    parameter int fifoDepth       = WB_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [rowBitWidth-1:0]     rowMax,
    input  logic [colBitWidth-1:0]     colMax,
    input  logic                       inValid,
`ifdef WB_CLAMP_EN
    input  logic signed [dataWidth+1:0] inData,
`else
    input  logic [dataWidth-1:0]       inData,
`endif
    output logic                       inReady,
    output logic                       wrEn,
    input  logic                       wrReady,
    output logic [addressBitWidth-1:0] wrAddress,
    output logic [dataWidth-1:0]       wrData,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = rowBitWidth + colBitWidth;

    wb_state_e                state_q, state_d;
    logic [rowBitWidth-1:0]   row_max_q, row_max_d;
    logic [colBitWidth-1:0]   col_max_q, col_max_d;
    logic [rowBitWidth-1:0]   row_q, row_d;
    logic [colBitWidth-1:0]   col_q, col_d;
    logic [addressBitWidth-1:0] row_base_q, row_base_d;
    logic [CNT_W-1:0]         accept_count_q, accept_count_d;
    logic [CNT_W-1:0]         total_q, total_d;
    logic                     done_q, done_d;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic [dataWidth-1:0]     fifo_din;
    logic                     start_ok;
    logic                     last_col;
    logic                     last_row;

    // Input conditioning
    always_comb begin
        fifo_din = '0;
`ifdef WB_CLAMP_EN
        if (inData[dataWidth+1]) begin
            fifo_din = '0;
        end else if (inData[dataWidth]) begin
            fifo_din = '1;
        end else begin
            fifo_din = inData[dataWidth-1:0];
        end
`else
        fifo_din = inData;
`endif
    end

    writeback_fifo #(
        .dataWidth (dataWidth),
        .fifoDepth (fifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (wrData),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        start_ok = start && (rowMax != '0) && (colMax != '0);
        inReady  = (state_q == WB_WRITE) && !fifo_full &&
                   (accept_count_q < total_q);
        wrEn     = (state_q == WB_WRITE) && !fifo_empty;
        push     = inValid && inReady;
        pop      = wrEn && wrReady;
        last_col = (col_q == col_max_q - colBitWidth'(1));
        last_row = (row_q == row_max_q - rowBitWidth'(1));
        wrAddress = row_base_q + addressBitWidth'(col_q);
        busy     = (state_q == WB_WRITE);
        done     = done_q;
    end

    always_comb begin
        state_d        = state_q;
        row_max_d      = row_max_q;
        col_max_d      = col_max_q;
        row_d          = row_q;
        col_d          = col_q;
        row_base_d     = row_base_q;
        accept_count_d = accept_count_q;
        total_d        = total_q;
        done_d         = done_q;

        unique case (state_q)
            WB_IDLE, WB_COMPLETE: begin
                if (start_ok) begin
                    state_d        = WB_WRITE;
                    row_max_d      = rowMax;
                    col_max_d      = colMax;
                    row_d          = '0;
                    col_d          = '0;
                    row_base_d     = '0;
                    accept_count_d = '0;
                    // Pixel budget for the push gate, computed once per frame
                    total_d        = CNT_W'(rowMax) * CNT_W'(colMax);
                    done_d         = 1'b0;
                end
            end
            WB_WRITE: begin
                if (push) begin
                    accept_count_d = accept_count_q + CNT_W'(1);
                end
                if (pop) begin
                    if (last_col) begin
                        col_d      = '0;
                        row_d      = row_q + rowBitWidth'(1);
                        row_base_d = row_base_q +
                                     addressBitWidth'(col_max_q);
                    end else begin
                        col_d = col_q + colBitWidth'(1);
                    end
                    if (last_row && last_col) begin
                        state_d = WB_COMPLETE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= WB_IDLE;
            row_max_q      <= '0;
            col_max_q      <= '0;
            row_q          <= '0;
            col_q          <= '0;
            row_base_q     <= '0;
            accept_count_q <= '0;
            total_q        <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_max_q      <= row_max_d;
            col_max_q      <= col_max_d;
            row_q          <= row_d;
            col_q          <= col_d;
            row_base_q     <= row_base_d;
            accept_count_q <= accept_count_d;
            total_q        <= total_d;
            done_q         <= done_d;
        end
    end

endmodule

// File: tb/tb_pixel_writeback.sv
// Self-checking bench for pixel_writeback: frame table, corner sequences
// and randomized frames against a queue-based reference model.
module tb_pixel_writeback;

    localparam int AW    = 17;
    localparam int RW    = 11;
    localparam int CW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef WB_CLAMP_EN
    localparam int IW = DW + 2;
`else
    localparam int IW = DW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] rowMax = '0;
    logic [CW-1:0] colMax = '0;
    logic          inValid = 1'b0;
    logic [IW-1:0] inData = '0;
    logic          inReady;
    logic          wrEn;
    logic          wrReady = 1'b0;
    logic [AW-1:0] wrAddress;
    logic [DW-1:0] wrData;
    logic          busy;
    logic          done;

    pixel_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rowMax    (rowMax),
        .colMax    (colMax),
        .inValid   (inValid),
        .inData    (inData),
        .inReady   (inReady),
        .wrEn      (wrEn),
        .wrReady   (wrReady),
        .wrAddress (wrAddress),
        .wrData    (wrData),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: a frame is a sequence of pixels; the k-th one
    // written lands at linear address k.
    logic [DW-1:0] m_q[$];
    bit m_wr   = 0;
    bit m_done = 0;
    int m_total = 0;
    int m_acc   = 0;
    int m_pop   = 0;

    // Handshakes observed on the DUT's own ports
    int n_push    = 0;
    int n_pop     = 0;
    int last_addr = -1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_pix(input logic [IW-1:0] d);
`ifdef WB_CLAMP_EN
        int v;
        v = int'($signed(d));
        if (v < 0) return '0;
        if (v > (1 << DW) - 1) return '1;
        return DW'(v);
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_wr = 0;
        m_done = 0;
        m_total = 0;
        m_acc = 0;
        m_pop = 0;
    endtask

    // Check this cycle's outputs, then advance one clock
    task automatic cycle();
        bit e_rdy, e_wen, push, pop, was_wr;
        logic [DW-1:0] pix;
        e_rdy = m_wr && (m_q.size() < DEPTH) && (m_acc < m_total);
        e_wen = m_wr && (m_q.size() > 0);
        chk("inReady", 64'(inReady), 64'(e_rdy));
        chk("wrEn", 64'(wrEn), 64'(e_wen));
        chk("busy", 64'(busy), 64'(m_wr));
        chk("done", 64'(done), 64'(m_done));
        if (e_wen) begin
            chk("wrAddress", 64'(wrAddress), 64'(m_pop % (1 << AW)));
            chk("wrData", 64'(wrData), 64'(m_q[0]));
        end
        if (inValid && inReady) n_push++;
        if (wrEn && wrReady) begin
            n_pop++;
            last_addr = int'(wrAddress);
        end
        push = rst && inValid && e_rdy;
        pop  = rst && e_wen && wrReady;
        pix  = ref_pix(inData);
        was_wr = m_wr;
        @(posedge clk);
        if (pop) begin
            void'(m_q.pop_front());
            m_pop++;
            if (m_pop == m_total) begin
                m_wr = 0;
                m_done = 1;
            end
        end
        if (push) begin
            m_q.push_back(pix);
            m_acc++;
        end
        if (rst && !was_wr && start && rowMax != 0 && colMax != 0) begin
            m_q.delete();
            m_wr = 1;
            m_done = 0;
            m_total = int'(rowMax) * int'(colMax);
            m_acc = 0;
            m_pop = 0;
        end
        #1;
    endtask

    task automatic start_frame(input int r, input int c);
        n_push = 0;
        n_pop = 0;
        last_addr = -1;
        inValid = 0;
        start = 1;
        rowMax = RW'(r);
        colMax = CW'(c);
        cycle();
        start = 0;
    endtask

    task automatic finish_frame(input int pv, input int pr, input bit spur);
        int budget;
        budget = 5000;
        while (!m_done && budget > 0) begin
            inValid = ($urandom_range(99) < pv);
            wrReady = ($urandom_range(99) < pr);
            inData  = IW'($urandom);
            if (spur && $urandom_range(19) == 0) begin
                start  = 1;
                rowMax = RW'($urandom_range(5, 1));
                colMax = CW'($urandom_range(5, 1));
            end else begin
                start = 0;
            end
            cycle();
            budget--;
        end
        start = 0;
        inValid = 0;
        if (!m_done) chk("frame_timeout", 0, 1);
    endtask

    task automatic async_reset_check();
        rst = 0;
        #1;
        chk("rst_inReady", 64'(inReady), 0);
        chk("rst_wrEn", 64'(wrEn), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        model_reset();
    endtask

    typedef struct {
        int rows;
        int cols;
        int pv;
        int pr;
        int exp_writes;
        int exp_last;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{2, 3, 100, 100, 6, 5};
        tbl[1] = '{1, 1, 100, 100, 1, 0};
        tbl[2] = '{3, 4, 70, 60, 12, 11};
        tbl[3] = '{1, 7, 50, 50, 7, 6};
        tbl[4] = '{5, 1, 80, 30, 5, 4};
        tbl[5] = '{4, 4, 100, 20, 16, 15};
        tbl[6] = '{6, 5, 40, 90, 30, 29};

        // Reset state
        model_reset();
        #2;
        chk("reset_inReady", 64'(inReady), 0);
        chk("reset_wrEn", 64'(wrEn), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_done", 64'(done), 0);
        repeat (2) cycle();
        rst = 1;
        cycle();

        // Zero-dimension start in IDLE is ignored
        start = 1;
        rowMax = 0;
        colMax = 3;
        cycle();
        start = 0;
        chk("zero_dim_busy", 64'(busy), 0);
        cycle();

        // Frame table
        foreach (tbl[i]) begin
            start_frame(tbl[i].rows, tbl[i].cols);
            finish_frame(tbl[i].pv, tbl[i].pr, 0);
            chk("tbl_writes", 64'(n_pop), 64'(tbl[i].exp_writes));
            chk("tbl_last_addr", 64'(last_addr), 64'(tbl[i].exp_last));
            cycle();
            chk("tbl_done_holds", 64'(done), 1);
        end

        // Invalid start in COMPLETE leaves done set
        start = 1;
        rowMax = 2;
        colMax = 0;
        cycle();
        start = 0;
        chk("complete_zero_done", 64'(done), 1);

        // Stalled memory: FIFO fills after DEPTH pushes
        start_frame(3, 4);
        inValid = 1;
        wrReady = 0;
        repeat (10) begin
            inData = IW'($urandom);
            cycle();
        end
        chk("stall_pushes", 64'(n_push), 64'(DEPTH));
        chk("stall_addr", 64'(wrAddress), 0);
        finish_frame(100, 100, 0);
        chk("stall_writes", 64'(n_pop), 12);

        // Over-supply: only rowMax*colMax pixels consumed
        start_frame(2, 2);
        finish_frame(100, 100, 0);
        chk("oversupply_pushes", 64'(n_push), 4);

        // Reset on the third pixel of a 4x4 frame
        start_frame(4, 4);
        inValid = 1;
        wrReady = 1;
        for (int k = 0; k < 20 && n_push < 2; k++) begin
            inData = IW'($urandom);
            cycle();
        end
        chk("pre_reset_pushes", 64'(n_push), 2);
        async_reset_check();
        inValid = 0;
        repeat (2) cycle();
        rst = 1;
        cycle();
        start_frame(2, 2);
        finish_frame(100, 100, 0);
        chk("post_reset_writes", 64'(n_pop), 4);
        chk("post_reset_last", 64'(last_addr), 3);

        // Restart from COMPLETE with a 1x1 frame
        start_frame(1, 1);
        chk("restart_done_clear", 64'(done), 0);
        finish_frame(100, 100, 0);
        chk("restart_writes", 64'(n_pop), 1);
        chk("restart_addr", 64'(last_addr), 0);

`ifdef WB_CLAMP_EN
        begin
            logic [IW-1:0] cin[3];
            logic [DW-1:0] cexp[3];
            cin[0] = IW'(-5);
            cin[1] = IW'(300);
            cin[2] = IW'(127);
            cexp[0] = 8'd0;
            cexp[1] = 8'd255;
            cexp[2] = 8'd127;
            start_frame(1, 3);
            wrReady = 0;
            for (int i = 0; i < 3; i++) begin
                inValid = 1;
                inData = cin[i];
                cycle();
            end
            inValid = 0;
            wrReady = 1;
            for (int i = 0; i < 3; i++) begin
                chk("clamp_data", 64'(wrData), 64'(cexp[i]));
                cycle();
            end
            chk("clamp_done", 64'(done), 1);
        end
`endif

        // Randomized frames with stray start pulses mid-frame
        for (int f = 0; f < 8; f++) begin
            int r, c;
            r = $urandom_range(8, 1);
            c = $urandom_range(8, 1);
            start_frame(r, c);
            finish_frame($urandom_range(100, 20), $urandom_range(100, 20), 1);
            chk("rand_writes", 64'(n_pop), 64'(r * c));
            chk("rand_last", 64'(last_addr), 64'(r * c - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
